// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: state encoding and
// the counter-width helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bits needed to count 0..value-1; callers guarantee value >= 2.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit combinational full adder; the only arithmetic in the serial adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, one bit per clock through
// a single full-adder cell, with start/done handshake and overflow detection.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = clog2(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic             s_bit;
    logic             c_bit;
    logic             accept;
    logic             last_bit;

    fa_cell u_fa (
        .a  (op_a[0]),
        .b  (op_b[0]),
        .ci (carry),
        .s  (s_bit),
        .co (c_bit)
    );

    always_comb begin
        accept     = ((state == S_IDLE) || (state == S_DONE)) && start;
        last_bit   = (state == S_RUN) && (cnt == CW'(WIDTH - 1));
        state_next = state;
        case (state)
            S_IDLE:  state_next = start ? S_RUN : S_IDLE;
            S_RUN:   state_next = last_bit ? S_DONE : S_RUN;
            S_DONE:  state_next = start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Subtraction is A + ~B + ~borrow_in, so cout reads as "no borrow".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= cin ^ sub;
        end else if (state == S_RUN) begin
            sum   <= {s_bit, sum[WIDTH-1:1]};
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            carry <= c_bit;
            cnt   <= cnt + CW'(1);
            if (last_bit) begin
                cout <= c_bit;
                ovf  <= carry ^ c_bit;
            end
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases, randomized ops against
// an arithmetic reference model, back-to-back, mid-run reset, WIDTH=2 sweep.
module tb_serial_adder;

    typedef struct {
        longint unsigned sum;
        bit              cout;
        bit              ovf;
    } res_t;

    logic       clk;
    logic       rst_n;

    logic       start8, cin8, sub8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;

    logic       start2, cin2, sub2, busy2, done2, cout2, ovf2;
    logic [1:0] a2, b2, sum2;

    int checks;
    int errors;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .sub(sub8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .sub(sub2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plain integer arithmetic: unsigned result modulo 2^w, carry / no-borrow,
    // and signed range check for overflow.
    function automatic res_t ref_model(input int w, input longint a, input longint b,
                                       input bit cin, input bit sub);
        res_t   r;
        longint pw, half, sa, sb, u, s;
        pw   = longint'(1) << w;
        half = pw / 2;
        sa   = (a >= half) ? a - pw : a;
        sb   = (b >= half) ? b - pw : b;
        if (!sub) begin
            u      = a + b + longint'(cin);
            r.cout = (u >= pw);
            s      = sa + sb + longint'(cin);
        end else begin
            u      = a - b - longint'(cin);
            r.cout = (a >= b + longint'(cin));
            s      = sa - sb - longint'(cin);
        end
        r.sum = longint'(u) & (pw - 1);
        r.ovf = (s > half - 1) || (s < -half);
        return r;
    endfunction

    // Issues one op on the 8-bit DUT and waits (bounded) for done.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit cin,
                        input bit sub, output int lat, output int busy_n,
                        output bit overlap);
        a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = 1'b1;
        @(posedge clk); #1;
        start8  = 1'b0;
        lat     = 0;
        busy_n  = 0;
        overlap = 1'b0;
        while (!done8 && lat < 20) begin
            if (busy8) busy_n++;
            @(posedge clk); #1;
            lat++;
            if (busy8 && done8) overlap = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
        start2 = 0; a2 = 0; b2 = 0; cin2 = 0; sub2 = 0;
        #12;
        checks++;
        if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
            errors++;
            $display("FAIL reset8 got busy=%b done=%b sum=%h cout=%b ovf=%b exp all 0",
                     busy8, done8, sum8, cout8, ovf8);
        end
        checks++;
        if ({busy2, done2, sum2, cout2, ovf2} !== 6'h00) begin
            errors++;
            $display("FAIL reset2 got busy=%b done=%b sum=%h cout=%b ovf=%b exp all 0",
                     busy2, done2, sum2, cout2, ovf2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [7:0] ta[5] = '{8'h3C, 8'hFF, 8'hFF, 8'h10, 8'h80};
        logic [7:0] tb[5] = '{8'h45, 8'h01, 8'h01, 8'h20, 8'h01};
        bit         tc[5] = '{0, 0, 1, 0, 0};
        bit         ts[5] = '{0, 0, 0, 1, 1};
        logic [7:0] es[5] = '{8'h81, 8'h00, 8'h01, 8'hF0, 8'h7F};
        bit         ec[5] = '{0, 1, 1, 0, 1};
        bit         eo[5] = '{1, 0, 0, 0, 1};
        int lat, busy_n;
        bit overlap;
        for (int i = 0; i < 5; i++) begin
            run8(ta[i], tb[i], tc[i], ts[i], lat, busy_n, overlap);
            checks++;
            if ({sum8, cout8, ovf8} !== {es[i], ec[i], eo[i]}) begin
                errors++;
                $display("FAIL directed%0d got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                         i, sum8, cout8, ovf8, es[i], ec[i], eo[i]);
            end
            checks++;
            if (lat != 8 || busy_n != 8 || overlap) begin
                errors++;
                $display("FAIL timing%0d got done_after=%0d busy_cycles=%0d overlap=%b exp 8 8 0",
                         i, lat, busy_n, overlap);
            end
            @(posedge clk); #1;
            checks++;
            if (done8 !== 1'b0 || busy8 !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse%0d got done=%b busy=%b exp 0 0", i, done8, busy8);
            end
        end
    endtask

    task automatic test_random();
        res_t r;
        logic [7:0] a, b;
        bit cin, sub;
        int lat, busy_n;
        bit overlap;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            r = ref_model(8, longint'(a), longint'(b), cin, sub);
            run8(a, b, cin, sub, lat, busy_n, overlap);
            checks++;
            if (lat != 8 || {sum8, cout8, ovf8} !== {r.sum[7:0], r.cout, r.ovf}) begin
                errors++;
                $display("FAIL random%0d a=%h b=%h cin=%b sub=%b got sum=%h cout=%b ovf=%b lat=%0d exp sum=%h cout=%b ovf=%b lat=8",
                         i, a, b, cin, sub, sum8, cout8, ovf8, lat, r.sum[7:0], r.cout, r.ovf);
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t r1, r2;
        logic [7:0] a1, b1, a2v, b2v;
        int n, m;
        a1 = 8'h5A; b1 = 8'h33; a2v = 8'hC4; b2v = 8'h7E;
        r1 = ref_model(8, longint'(a1), longint'(b1), 1'b1, 1'b0);
        r2 = ref_model(8, longint'(a2v), longint'(b2v), 1'b0, 1'b1);
        a8 = a1; b8 = b1; cin8 = 1'b1; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!done8 && n < 20) begin
            a8 = 8'($urandom); b8 = 8'($urandom);
            cin8 = 1'($urandom); sub8 = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != 8 || {sum8, cout8, ovf8} !== {r1.sum[7:0], r1.cout, r1.ovf}) begin
            errors++;
            $display("FAIL held_start got sum=%h cout=%b ovf=%b lat=%0d exp sum=%h cout=%b ovf=%b lat=8",
                     sum8, cout8, ovf8, n, r1.sum[7:0], r1.cout, r1.ovf);
        end
        a8 = a2v; b8 = b2v; cin8 = 1'b0; sub8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept got busy=%b exp 1", busy8);
        end
        m = 1;
        while (!done8 && m < 20) begin
            @(posedge clk); #1;
            m++;
        end
        checks++;
        if (m != 9 || {sum8, cout8, ovf8} !== {r2.sum[7:0], r2.cout, r2.ovf}) begin
            errors++;
            $display("FAIL b2b_second got sum=%h cout=%b ovf=%b gap=%0d exp sum=%h cout=%b ovf=%b gap=9",
                     sum8, cout8, ovf8, m, r2.sum[7:0], r2.cout, r2.ovf);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        int lat, busy_n;
        bit overlap, saw_done;
        run8(8'hFF, 8'hFF, 1'b1, 1'b0, lat, busy_n, overlap);
        a8 = 8'h7F; b8 = 8'h7F; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
            errors++;
            $display("FAIL midrun_reset got busy=%b done=%b sum=%h cout=%b ovf=%b exp all 0",
                     busy8, done8, sum8, cout8, ovf8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done8 || busy8) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL abort_no_done got activity=1 exp 0");
        end
        run8(8'h12, 8'h34, 1'b1, 1'b0, lat, busy_n, overlap);
        checks++;
        if (lat != 8 || {sum8, cout8, ovf8} !== {8'h47, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL after_reset got sum=%h cout=%b ovf=%b lat=%0d exp sum=47 cout=0 ovf=0 lat=8",
                     sum8, cout8, ovf8, lat);
        end
    endtask

    task automatic test_width2_sweep();
        res_t r;
        int n;
        for (int i = 0; i < 64; i++) begin
            a2 = 2'(i); b2 = 2'(i >> 2); cin2 = 1'(i >> 4); sub2 = 1'(i >> 5);
            r = ref_model(2, longint'(a2), longint'(b2), cin2, sub2);
            start2 = 1'b1;
            @(posedge clk); #1;
            start2 = 1'b0;
            n = 0;
            while (!done2 && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            checks++;
            if (n != 2 || {sum2, cout2, ovf2} !== {r.sum[1:0], r.cout, r.ovf}) begin
                errors++;
                $display("FAIL w2_case%0d a=%h b=%h cin=%b sub=%b got sum=%h cout=%b ovf=%b lat=%0d exp sum=%h cout=%b ovf=%b lat=2",
                         i, a2, b2, cin2, sub2, sum2, cout2, ovf2, n, r.sum[1:0], r.cout, r.ovf);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        test_width2_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
